// File: rtl/neuron_train_sequencer_pkg.sv
// Shared types for the training sequencer: the zero2one_t sample element,
// the error-sum width derived from it and the sequencer state encoding.
package neuron_train_sequencer_pkg;

    localparam int ZW = 8;
    typedef logic [ZW-1:0] zero2one_t;

    // Four unsigned lane differences need two bits of headroom above one element.
    function automatic int err_width(input int elem_w);
        return elem_w + 2;
    endfunction

    localparam int ERR_W = err_width($bits(zero2one_t));

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        LEARN,
        ADVANCE
    } train_state_t;

endpackage

// File: rtl/zero2one_abs_err_sum.sv
// Combinational sum of |out[k] - exp[k]| over the four output lanes of a layer.
module zero2one_abs_err_sum
    import neuron_train_sequencer_pkg::*;
(
    input  logic [4*ZW-1:0]  out_vec,
    input  logic [4*ZW-1:0]  exp_vec,
    output logic [ERR_W-1:0] err
);

    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default first, so the running sum cannot infer a latch.
    always_comb begin
        err = '0;
        for (int k = 0; k < 4; k++) begin
            if (out_vec[k*ZW +: ZW] >= exp_vec[k*ZW +: ZW])
                err = err + ERR_W'(out_vec[k*ZW +: ZW] - exp_vec[k*ZW +: ZW]);
            else
                err = err + ERR_W'(exp_vec[k*ZW +: ZW] - out_vec[k*ZW +: ZW]);
        end
    end

endmodule

// File: rtl/neuron_train_sequencer.sv
// Presents buffered training samples to the 4-neuron layer, one settle/learn
// slot per sample, and tracks per-sample error and per-epoch hit counts.
module neuron_train_sequencer
    import neuron_train_sequencer_pkg::*;
#(
    parameter int N      = 16,
    parameter int DEPTH  = 8,
    parameter int SETTLE = 2,
    parameter int EPOCHS = 4,
    parameter int TOL    = 8
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [N*ZW-1:0]          load_in,
    input  logic [4*ZW-1:0]          load_expected,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              epoch,
    output logic [$clog2(DEPTH):0]   hits,
    output logic [ERR_W-1:0]         last_err,
    output logic                     layer_valid,
    output logic                     layer_learn,
    output logic [N*ZW-1:0]          layer_in,
    output logic [4*ZW-1:0]          layer_expected_out,
    input  logic [4*ZW-1:0]          layer_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(SETTLE + 1);

    train_state_t     state;
    logic [N*ZW-1:0]  buf_in  [DEPTH];
    logic [4*ZW-1:0]  buf_exp [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    next_idx;
    logic [SW-1:0]    settle_cnt;
    logic [CW-1:0]    acc;
    logic [ERR_W-1:0] err;
    logic [15:0]      next_epoch;
    logic             wr_en;
    logic             start_ok;
    logic             is_last;

    zero2one_abs_err_sum u_err (
        .out_vec (layer_out),
        .exp_vec (layer_expected_out),
        .err     (err)
    );

    assign load_ready = (state == IDLE) && (count != CW'(DEPTH));
    assign busy       = (state != IDLE);
    assign wr_en      = load_valid && load_ready && !clear;
    assign start_ok   = (state == IDLE) && start && !abort && (count != '0);
    assign is_last    = ({1'b0, idx} == count - CW'(1));
    assign next_idx   = is_last ? '0 : idx + AW'(1);
    assign next_epoch = epoch + 16'd1;

    // NOTE: the sample buffer is plain storage and deliberately has no reset;
    // only entries below count are ever presented to the layer.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_in[wptr]  <= load_in;
            buf_exp[wptr] <= load_expected;
        end
    end

    // NOTE: all registered state uses non-blocking '<=' so every branch sees
    // the pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state              <= IDLE;
            count              <= '0;
            wptr               <= '0;
            idx                <= '0;
            settle_cnt         <= '0;
            acc                <= '0;
            epoch              <= '0;
            hits               <= '0;
            last_err           <= '0;
            done               <= 1'b0;
            layer_valid        <= 1'b0;
            layer_learn        <= 1'b0;
            layer_in           <= '0;
            layer_expected_out <= '0;
        end else begin
            done <= 1'b0;

            if (state == IDLE) begin
                if (clear) begin
                    count <= '0;
                    wptr  <= '0;
                end else if (wr_en) begin
                    count <= count + CW'(1);
                    wptr  <= wptr + AW'(1);
                end
            end

            if (abort && state != IDLE) begin
                state       <= IDLE;
                layer_valid <= 1'b0;
                layer_learn <= 1'b0;
                acc         <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            state              <= PRESENT;
                            idx                <= '0;
                            epoch              <= '0;
                            acc                <= '0;
                            settle_cnt         <= '0;
                            layer_valid        <= 1'b1;
                            layer_learn        <= 1'b0;
                            layer_in           <= buf_in[0];
                            layer_expected_out <= buf_exp[0];
                        end
                    end
                    PRESENT: begin
                        // Layer output is judged only after the full settle window.
                        if (settle_cnt == SW'(SETTLE - 1)) begin
                            last_err    <= err;
                            if (err <= ERR_W'(TOL))
                                acc <= acc + CW'(1);
                            layer_learn <= 1'b1;
                            state       <= LEARN;
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end
                    LEARN: begin
                        layer_valid <= 1'b0;
                        layer_learn <= 1'b0;
                        state       <= ADVANCE;
                    end
                    ADVANCE: begin
                        idx <= next_idx;
                        if (is_last) begin
                            epoch <= next_epoch;
                            hits  <= acc;
                            acc   <= '0;
                        end
                        if (is_last && EPOCHS != 0 && next_epoch == 16'(EPOCHS)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state              <= PRESENT;
                            settle_cnt         <= '0;
                            layer_valid        <= 1'b1;
                            layer_in           <= buf_in[next_idx];
                            layer_expected_out <= buf_exp[next_idx];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/neuron_train_sequencer.md
Name: neuron_train_sequencer

Overview:
Training-sample sequencer directly upstream of the 4-neuron learning layer. Holds a small buffer of (input vector, expected output) samples, drives the layer's in/expected_out/valid/learn pins one sample at a time, and samples the layer's out. Per sample it computes the summed absolute error against the target and counts hits per epoch. The only control sink for the layer during training.

Parameters:
N, 16, input vector length; matches the layer's N
DEPTH, 8, sample buffer entries (power of two, >=2)
SETTLE, 2, cycles with valid=1, learn=0 before out is sampled (>=1)
EPOCHS, 4, epochs per run; 0 = run until abort
TOL, 8, hit threshold on summed abs error, in zero2one_t LSBs

Ports:
clock  in  1  system clock
rst_n  in  1  synchronous active-low reset
load_valid  in  1  write one sample into buffer
load_ready  out  1  buffer accepts writes (IDLE and not full)
load_in  in  N x zero2one_t  sample input vector
load_expected  in  4 x zero2one_t  sample target
clear  in  1  empty the buffer (IDLE only, else ignored)
start  in  1  begin a run (IDLE, count>0, else ignored)
abort  in  1  stop run, return to IDLE
busy  out  1  run in progress
done  out  1  one-cycle pulse at normal run completion
count  out  clog2(DEPTH)+1  samples stored
epoch  out  16  epochs completed in current or last run
hits  out  clog2(DEPTH)+1  hits in last completed epoch
last_err  out  W+2  summed abs error of last sampled sample (W = $bits(zero2one_t))
layer_valid  out  1  to layer valid
layer_learn  out  1  to layer learn
layer_in  out  N x zero2one_t  to layer in
layer_expected_out  out  4 x zero2one_t  to layer expected_out
layer_out  in  4 x zero2one_t  from layer out

Behaviour:
Reset (rst_n=0 at clock edge): state IDLE, count=0, write ptr=0, epoch=0, hits=0, last_err=0, done=0, busy=0, layer_valid=0, layer_learn=0, layer_in and layer_expected_out all zero. Buffer contents need not reset. Reset mid-run: same values next cycle, no done pulse.
Buffer: write at wptr on load_valid&&load_ready; count++. Full (count==DEPTH): load_ready=0, writes dropped. clear in IDLE: count=0, wptr=0; clear and load_valid same cycle: clear wins.
FSM states: IDLE, PRESENT, LEARN, ADVANCE.
- IDLE: busy=0, layer_valid=0. start with count>0 -> PRESENT, idx=0, epoch=0, epoch hit accumulator=0. start with count=0 ignored.
- PRESENT: layer_valid=1, layer_learn=0, layer_in/expected from buffer[idx] (registered outputs, stable for whole sample). Settle counter runs SETTLE cycles; in last PRESENT cycle sample layer_out: err = sum over 4 of |out[k]-expected[k]|, unsigned, W+2 bits, no saturation. last_err<=err; if err<=TOL, hit accumulator++. -> LEARN.
- LEARN: exactly one cycle, layer_valid=1, layer_learn=1, same operands. -> ADVANCE.
- ADVANCE: one cycle, layer_valid=0, layer_learn=0. If idx==count-1: idx=0, epoch++, hits<=accumulator, accumulator=0; if EPOCHS!=0 and new epoch==EPOCHS -> IDLE with done=1 that cycle's next edge (done high for one cycle upon entering IDLE); else -> PRESENT. Otherwise idx++ -> PRESENT.
- Per-sample latency: SETTLE+2 cycles; per epoch count*(SETTLE+2).
abort: in any non-IDLE state, next state IDLE, layer_valid=layer_learn=0, no done, epoch/hits keep current values, accumulator discarded. abort and start same cycle in IDLE: abort wins. start while busy ignored.
Buffer writes and clear ignored while busy (load_ready=0).
epoch wraps at 2^16 when EPOCHS=0.

Decomposition:
Package additions: ERR_W function of $bits(zero2one_t), train_state_t enum {IDLE, PRESENT, LEARN, ADVANCE}. zero2one_t from existing shared defs.
Sub-module: zero2one_abs_err_sum (combinational 4-lane abs-diff sum, width ERR_W), reusable by other layers.

Test Plan:
Reset then load 3 samples -> count=3, load_ready=1; load 5 more -> count=8, load_ready=0; 9th write dropped, count stays 8.
Load 2 samples, EPOCHS=4, SETTLE=2, start -> layer_valid high 3 cycles, learn high only in 3rd, low 1 cycle, repeat; done pulses once after 4*2*4=32 cycles; epoch=4.
Layer model returns out==expected -> last_err=0, hits=2 per epoch; model returns each out offset by +3 -> last_err=12, hits=0 with TOL=8.
Abort during LEARN of sample 1, epoch 1 -> next cycle busy=0, layer_valid=0, no done, epoch=1.
rst_n low mid-PRESENT -> all outputs reset values next cycle, count=0.
start with count=0, and clear+load_valid same cycle -> no run starts; count=0.
